// File: rtl/adder_bist_pkg.sv
// Shared definitions for the adder BIST initiator.
// Contents: FSM state encoding and the default operand width and settle window.
package adder_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DEF_WIDTH         = 4;
  localparam int DEF_SETTLE_CYCLES = 2;

endpackage

// File: rtl/adder_golden.sv
// Golden 2's-complement adder model, purely combinational.
// Ports:
//   a, b       in   WIDTH  operands
//   exp_sum    out  WIDTH  expected sum (low WIDTH bits of a+b)
//   exp_carry  out  1      expected unsigned carry out
//   exp_ovf    out  1      expected signed overflow
module adder_golden
  import adder_bist_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] exp_sum,
  output logic             exp_carry,
  output logic             exp_ovf
);

  logic [WIDTH:0] full;

  assign full      = {1'b0, a} + {1'b0, b};
  assign exp_sum   = full[WIDTH-1:0];
  assign exp_carry = full[WIDTH];
  // Signed overflow: operands share a sign that the result does not.
  assign exp_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/adder_bist.sv
// Built-in self-test initiator for a WIDTH-bit full adder.
// Sweeps every {a,b} pair (a-major), holds each for SETTLE_CYCLES clocks,
// then checks sum/carry/overflow against adder_golden. Counts mismatches
// and records the first failing operand pair.
// Ports:
//   clk          in   1          clock, rising edge
//   reset        in   1          synchronous active-high, clears all state
//   start        in   1          begin a sweep (honoured in IDLE or DONE)
//   a_out        out  WIDTH      operand a to the adder
//   b_out        out  WIDTH      operand b to the adder
//   sum_in       in   WIDTH      adder sum
//   carryout_in  in   1          adder carry out
//   overflow_in  in   1          adder overflow
//   busy         out  1          sweep in progress
//   done         out  1          sweep complete, held until start/reset
//   pass         out  1          no mismatches (valid while done)
//   err_count    out  2*WIDTH+1  mismatch count
//   fail_a       out  WIDTH      a of first mismatch
//   fail_b       out  WIDTH      b of first mismatch
module adder_bist
  import adder_bist_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [WIDTH-1:0]     a_out,
  output logic [WIDTH-1:0]     b_out,
  input  logic [WIDTH-1:0]     sum_in,
  input  logic                 carryout_in,
  input  logic                 overflow_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH:0]     err_count,
  output logic [WIDTH-1:0]     fail_a,
  output logic [WIDTH-1:0]     fail_b
);

  localparam int VEC_W = 2 * WIDTH;
  localparam int ERR_W = 2 * WIDTH + 1;
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t             state;
  logic [VEC_W-1:0]   vec;
  logic [CNT_W-1:0]   settle_cnt;
  logic [WIDTH-1:0]   exp_sum;
  logic               exp_carry;
  logic               exp_ovf;
  logic               mismatch;
  logic [ERR_W-1:0]   err_next;

  // Saturating increment; the count cannot reach all-ones in practice,
  // but the guard makes wrap structurally impossible.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  assign a_out = vec[VEC_W-1:WIDTH];
  assign b_out = vec[WIDTH-1:0];

  adder_golden #(.WIDTH(WIDTH)) u_golden (
    .a         (a_out),
    .b         (b_out),
    .exp_sum   (exp_sum),
    .exp_carry (exp_carry),
    .exp_ovf   (exp_ovf)
  );

  // Case-inequality so X/Z from the adder is flagged in simulation.
  assign mismatch = (sum_in !== exp_sum) || (carryout_in !== exp_carry) ||
                    (overflow_in !== exp_ovf);

  always_comb begin
    err_next = err_count;
    if (mismatch) err_next = sat_inc(err_count);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      vec        <= '0;
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_a     <= '0;
      fail_b     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            vec        <= '0;
            settle_cnt <= '0;
            err_count  <= '0;
            fail_a     <= '0;
            fail_b     <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            busy       <= 1'b1;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            state <= CHECK;
          end else begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end
        end
        CHECK: begin
          err_count <= err_next;
          if (mismatch && (err_count == '0)) begin
            fail_a <= a_out;
            fail_b <= b_out;
          end
          if (&vec) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
            state <= DONE;
          end else begin
            vec        <= vec + VEC_W'(1);
            settle_cnt <= '0;
            state      <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
